mem: RTL and testbench

Single-port, word-addressed RAM with a synchronous write and an asynchronous (combinational) read. It is the generic storage primitive for register files, small lookup tables and scratch buffers. A synchronous reset clears every word. It ships with `clock`, a simulation-only free-running clock source used by its benches.

---
 rtl/mem.sv | 37 +++
 tb/tb_mem.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem.sv
// Single-port word-addressed RAM: synchronous write and clear, combinational read.
// Used as the generic storage primitive for register files, small lookup
// tables and scratch buffers. Depth is 2**ADDR words of WORD bits each.
module mem #(
    parameter int ADDR = 8,
    parameter int WORD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ADDR-1:0] addr,
    input  logic [WORD-1:0] data_in,
    input  logic            wr,
    output logic [WORD-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR;

    // Storage array; contents are undefined until the first reset edge.
    logic [WORD-1:0] mem_r [DEPTH];

    // Reset clears every word and takes priority over a write on the same
    // edge; otherwise a write stores data_in as-is (no X/Z sanitising).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i[ADDR-1:0]] <= '0;
            end
        end else if (wr) begin
            mem_r[addr] <= data_in;
        end
    end

    // Read is purely combinational so data_out tracks addr within the cycle
    // and shows newly written data right after the capturing edge.
    assign data_out = mem_r[addr];

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem (ADDR=4, WORD=4) clocked by the simulation-only
// clock source. Inputs change on the falling edge; outputs are sampled on the
// falling edge, half a period away from the capturing rising edge.

// Free-running simulation clock: starts at 0, toggles every HALF_PERIOD.
module clock #(
    parameter int HALF_PERIOD = 1
) (
    output logic clk
);
    initial begin
        clk = 1'b0;
        forever #HALF_PERIOD clk = ~clk;
    end
endmodule

module tb_mem;

    logic       clk;
    logic       rst;
    logic [3:0] addr;
    logic [3:0] data_in;
    logic       wr;
    logic [3:0] data_out;

    int checks;
    int errors;

    clock #(.HALF_PERIOD(1)) u_clock (.clk(clk));

    mem #(.ADDR(4), .WORD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .wr      (wr),
        .data_out(data_out)
    );

    // Write one word across one rising edge; returns on the following falling edge.
    task automatic write_word(input logic [3:0] a, input logic [3:0] d);
        addr    = a;
        data_in = d;
        wr      = 1'b1;
        @(negedge clk);
        wr      = 1'b0;
    endtask

    // Present an address with wr low and return data_out one period later.
    task automatic read_word(input logic [3:0] a, output logic [3:0] d);
        addr = a;
        wr   = 1'b0;
        @(negedge clk);
        d = data_out;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            read_word(4'(a), got);
            checks++;
            if (got !== 4'd0) begin
                errors++;
                $display("FAIL reset_clear addr=%0d got=%h expected=0", a, got);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] got;
        write_word(4'd2, 4'd7);
        write_word(4'd3, 4'd5);
        read_word(4'd2, got);
        checks++;
        if (got !== 4'd7) begin
            errors++;
            $display("FAIL basic_addr2 got=%h expected=7", got);
        end
        read_word(4'd3, got);
        checks++;
        if (got !== 4'd5) begin
            errors++;
            $display("FAIL basic_addr3 got=%h expected=5", got);
        end
    endtask

    task automatic test_isolation();
        logic [3:0] got;
        logic [3:0] exp;
        for (int a = 0; a < 16; a++) begin
            write_word(4'(a), 4'(15 - a));
        end
        write_word(4'd8, 4'd3);
        for (int a = 0; a < 16; a++) begin
            exp = (a == 8) ? 4'd3 : 4'(15 - a);
            read_word(4'(a), got);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL isolation addr=%0d got=%h expected=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_read_during_write();
        logic [3:0] got;
        write_word(4'd5, 4'd1);
        addr    = 4'd5;
        data_in = 4'd9;
        wr      = 1'b1;
        // Still before the capturing edge: old contents must be visible.
        got = data_out;
        checks++;
        if (got !== 4'd1) begin
            errors++;
            $display("FAIL rdw_before_edge got=%h expected=1", got);
        end
        @(negedge clk);
        got = data_out;
        checks++;
        if (got !== 4'd9) begin
            errors++;
            $display("FAIL rdw_after_edge got=%h expected=9", got);
        end
        wr      = 1'b0;
        data_in = 4'd4;
        @(negedge clk);
        @(negedge clk);
        got = data_out;
        checks++;
        if (got !== 4'd9) begin
            errors++;
            $display("FAIL rdw_wr_low_hold got=%h expected=9", got);
        end
    endtask

    task automatic test_reset_priority();
        logic [3:0] got;
        write_word(4'd2, 4'd7);
        rst     = 1'b1;
        wr      = 1'b1;
        addr    = 4'd3;
        data_in = 4'd6;
        @(negedge clk);
        rst = 1'b0;
        wr  = 1'b0;
        read_word(4'd3, got);
        checks++;
        if (got !== 4'd0) begin
            errors++;
            $display("FAIL reset_priority_addr3 got=%h expected=0", got);
        end
        read_word(4'd2, got);
        checks++;
        if (got !== 4'd0) begin
            errors++;
            $display("FAIL reset_priority_addr2 got=%h expected=0", got);
        end
    endtask

    task automatic test_boundary();
        logic [3:0] got;
        write_word(4'd0, 4'd10);
        write_word(4'd15, 4'd11);
        read_word(4'd0, got);
        checks++;
        if (got !== 4'd10) begin
            errors++;
            $display("FAIL boundary_addr0 got=%h expected=a", got);
        end
        read_word(4'd15, got);
        checks++;
        if (got !== 4'd11) begin
            errors++;
            $display("FAIL boundary_addr15 got=%h expected=b", got);
        end
        read_word(4'd1, got);
        checks++;
        if (got !== 4'd0) begin
            errors++;
            $display("FAIL boundary_addr1_untouched got=%h expected=0", got);
        end
        read_word(4'd14, got);
        checks++;
        if (got !== 4'd0) begin
            errors++;
            $display("FAIL boundary_addr14_untouched got=%h expected=0", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        write_word(4'd6, 4'd1);
        write_word(4'd6, 4'd2);
        write_word(4'd6, 4'd12);
        read_word(4'd6, got);
        checks++;
        if (got !== 4'd12) begin
            errors++;
            $display("FAIL back_to_back_last got=%h expected=c", got);
        end
        data_in = 4'd5;
        read_word(4'd6, got);
        read_word(4'd6, got);
        checks++;
        if (got !== 4'd12) begin
            errors++;
            $display("FAIL wr_low_no_change got=%h expected=c", got);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        wr      = 1'b0;
        addr    = 4'd0;
        data_in = 4'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_isolation();
        test_read_during_write();
        test_reset_priority();
        test_boundary();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #20000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
